// File: rtl/tnn_pkg.sv
// Shared types and constants for the TNN inference datapath.
package tnn_pkg;
  localparam int TNN_W  = 3;
  localparam int TNN_CH = 4;

  typedef enum logic {CMP_GT = 1'b0, CMP_GE = 1'b1} cmp_mode_e;

  function automatic int pop_width(input int ch);
    return $clog2(ch + 1);
  endfunction
endpackage

// File: rtl/tnn_cmp_lane.sv
// Single-channel unsigned comparator with TRUNC ignored LSBs.
// Approximate (CGP) lanes can replace this with the same port list.
module tnn_cmp_lane
  import tnn_pkg::*;
#(
  parameter int W     = TNN_W,
  parameter int TRUNC = 0
) (
  input  logic [W-1:0] feat,
  input  logic [W-1:0] thr,
  input  cmp_mode_e    mode,
  output logic         hit
);
  // Full-width shift keeps every input bit in use while dropping the LSBs.
  logic [W-1:0] a, b;
  assign a   = feat >> TRUNC;
  assign b   = thr >> TRUNC;
  assign hit = (mode == CMP_GE) ? (a >= b) : (a > b);
endmodule

// File: rtl/tnn_cmp_bank.sv
// CH-wide feature-vs-threshold comparator bank, two-stage elastic pipeline
// emitting the hit vector and its popcount.
module tnn_cmp_bank
  import tnn_pkg::*;
#(
  parameter int W     = TNN_W,
  parameter int CH    = TNN_CH,
  parameter int TRUNC = 0,
  localparam int PW   = pop_width(CH),
  localparam int IW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [W-1:0]    cfg_data,
  input  logic            cmp_mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH-1:0]   out_bits,
  output logic [PW-1:0]   out_pop,
  output logic [15:0]     out_count
);
  localparam int STAGES = 2;

  logic [CH-1:0][W-1:0] thr;
  logic [CH-1:0]        hit;
  logic [CH-1:0]        s1_bits;
  logic [PW-1:0]        s1_pop;
  logic [STAGES:1]      vld_pipe;
  logic                 s2_adv, accept;

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign in_ready  = !rst && (!vld_pipe[1] || s2_adv);
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_pipe[2];

  // Compare reads the registered thresholds, so a same-cycle write lands
  // only on later samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr <= '1;
    end else if (cfg_we && (int'(cfg_idx) < CH)) begin
      thr[cfg_idx] <= cfg_data;
    end
  end

  tnn_cmp_lane #(.W(W), .TRUNC(TRUNC)) u_lane [CH-1:0] (
    .feat (in_data),
    .thr  (thr),
    .mode (cmp_mode_e'(cmp_mode)),
    .hit  (hit)
  );

  always_comb begin
    s1_pop = '0;
    for (int i = 0; i < CH; i++) s1_pop = s1_pop + PW'(s1_bits[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      s1_bits   <= '0;
      out_bits  <= '0;
      out_pop   <= '0;
      out_count <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (accept)   s1_bits     <= hit;
      if (s2_adv)   vld_pipe[2] <= vld_pipe[1];
      if (s2_adv && vld_pipe[1]) begin
        out_bits <= s1_bits;
        out_pop  <= s1_pop;
      end
      if (out_valid && out_ready) out_count <= out_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_tnn_cmp_bank.sv
// Scoreboard bench: exact bank (TRUNC=0) and truncated bank (TRUNC=1) share stimulus.
module tb_tnn_cmp_bank;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [2:0]  cfg_data = '0;
  logic        cmp_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        out_ready = 1'b1;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [3:0]  out_bits0, out_bits1;
  logic [2:0]  out_pop0, out_pop1;
  logic [15:0] out_count0, out_count1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] b0;
    int         p0;
    logic [3:0] b1;
    int         p1;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  tnn_cmp_bank #(.W(3), .CH(4), .TRUNC(0)) dut0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cmp_mode(cmp_mode), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_bits(out_bits0),
    .out_pop(out_pop0), .out_count(out_count0));

  tnn_cmp_bank #(.W(3), .CH(4), .TRUNC(1)) dut1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cmp_mode(cmp_mode), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_bits(out_bits1),
    .out_pop(out_pop1), .out_count(out_count1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [11:0] pk(input int f0, input int f1, input int f2, input int f3);
    return {3'(f3), 3'(f2), 3'(f1), 3'(f0)};
  endfunction

  // Monitor: pop one expectation per output handshake of the exact bank.
  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready) begin
      chk("valid_t1", {31'd0, out_valid1}, 32'd1);
      if (q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bits_t0", {28'd0, out_bits0}, {28'd0, e.b0});
        chk("pop_t0",  {29'd0, out_pop0},  e.p0);
        chk("bits_t1", {28'd0, out_bits1}, {28'd0, e.b1});
        chk("pop_t1",  {29'd0, out_pop1},  e.p1);
      end
    end
  end

  // Entered and left at posedge+1; pushes the expectation once acceptance is certain.
  task automatic send(input logic [11:0] d, input logic m, input logic [3:0] b0, input int p0,
                      input logic [3:0] b1, input int p1);
    int n = 0;
    in_valid = 1'b1; in_data = d; cmp_mode = m;
    @(negedge clk);
    while (!in_ready0 && n < 50) begin @(negedge clk); n++; end
    if (!in_ready0) chk("send_timeout", 32'd0, 32'd1);
    else q.push_back('{b0: b0, p0: p0, b1: b1, p1: p1});
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg(input int idx, input int val);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_data = 3'(val);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
  endtask

  task automatic bulk(input int n);
    int acc = 0, cyc = 0;
    in_valid = 1'b1; in_data = '0; cmp_mode = 1'b0;
    while (acc < n && cyc < n + 100) begin
      @(negedge clk);
      if (in_ready0) begin
        q.push_back('{b0: 4'b0000, p0: 0, b1: 4'b0000, p1: 0});
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (acc < n) chk("bulk_timeout", acc, n);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready0}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst_out_bits", {28'd0, out_bits0}, 32'd0);
    chk("rst_out_pop", {29'd0, out_pop0}, 32'd0);
    chk("rst_out_count", {16'd0, out_count0}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready0}, 32'd1);
    @(posedge clk); #1;

    // Reset thresholds are all ones
    send(pk(1, 3, 6, 7), 1'b0, 4'b0000, 0, 4'b0000, 0);
    send(pk(1, 3, 6, 7), 1'b1, 4'b1000, 1, 4'b1100, 2);
    drain();

    // thr = {0,3,5,7}; latency checked on the first sample
    cfg(0, 0); cfg(1, 3); cfg(2, 5); cfg(3, 7);
    send(pk(1, 3, 6, 7), 1'b0, 4'b0101, 2, 4'b0100, 1);
    @(negedge clk);
    chk("lat_n1_valid", {31'd0, out_valid0}, 32'd0);
    @(negedge clk);
    chk("lat_n2_valid", {31'd0, out_valid0}, 32'd1);
    @(posedge clk); #1;
    send(pk(1, 3, 6, 7), 1'b1, 4'b1111, 4, 4'b1111, 4);
    drain();

    // Truncation: thr[0]=4, feature 5
    cfg(0, 4);
    send(pk(5, 3, 6, 7), 1'b0, 4'b0101, 2, 4'b0100, 1);
    send(pk(5, 3, 6, 7), 1'b1, 4'b1111, 4, 4'b1111, 4);
    drain();

    // Backpressure stream from a fresh reset
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    cfg(0, 0); cfg(1, 3); cfg(2, 5); cfg(3, 7);
    out_ready = 1'b0;
    fork
      begin
        send(pk(1, 4, 6, 7), 1'b1, 4'b1111, 4, 4'b1111, 4);
        send(pk(0, 0, 0, 0), 1'b0, 4'b0000, 0, 4'b0000, 0);
        send(pk(7, 2, 5, 6), 1'b0, 4'b0001, 1, 4'b0001, 1);
        send(pk(0, 7, 7, 0), 1'b0, 4'b0110, 2, 4'b0110, 2);
      end
      begin
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready0}, 32'd0);
        chk("stall_valid", {31'd0, out_valid0}, 32'd1);
        chk("stall_bits", {28'd0, out_bits0}, 32'hF);
        @(posedge clk); #1;
        chk("hold_valid", {31'd0, out_valid0}, 32'd1);
        chk("hold_bits", {28'd0, out_bits0}, 32'hF);
        chk("hold_in_ready", {31'd0, in_ready0}, 32'd0);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", {16'd0, out_count0}, 32'd4);

    // Same-cycle threshold write uses the old value
    cfg(2, 0);
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_data = 3'd7;
    send(pk(0, 0, 3, 0), 1'b0, 4'b0100, 1, 4'b0100, 1);
    send(pk(0, 0, 3, 0), 1'b0, 4'b0000, 0, 4'b0000, 0);
    drain();

    // Reset with two samples buffered
    out_ready = 1'b0;
    send(pk(7, 7, 7, 7), 1'b1, 4'b0000, 0, 4'b0000, 0);
    send(pk(7, 7, 7, 7), 1'b1, 4'b0000, 0, 4'b0000, 0);
    @(negedge clk);
    chk("buffered_valid", {31'd0, out_valid0}, 32'd1);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", {31'd0, out_valid0}, 32'd0);
    chk("midrst_count", {16'd0, out_count0}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;

    // out_count wrap
    bulk(65535);
    drain();
    chk("count_ffff", {16'd0, out_count0}, 32'hFFFF);
    bulk(1);
    drain();
    chk("count_wrap", {16'd0, out_count0}, 32'd0);
    chk("count_wrap_t1", {16'd0, out_count1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
